// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers hex digits from a multiplexed 7-segment bus
// Optional: define SEG7_SCAN_ACTIVE_LOW_SEG_EN for active-low (common-anode) segment lines.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic                    frame_valid,
    output logic                    err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t                  state, state_d;
    logic [6:0]              seg_m, seg_q, s_seg, ref_seg;
    logic [NUM_DIGITS-1:0]   an_m, an_q, s_an, ref_an, mask;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [CW-1:0]           cnt;
    logic                    same, one_low, load, inc, accept;
    logic [4:0]              dec;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;  7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;  7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;  7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;  7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;  7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;  7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;  7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;  7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '0;
            seg_q <= '0;
            an_m  <= '0;
            an_q  <= '0;
        end else begin
            seg_m <= seg_in;
            seg_q <= seg_m;
            an_m  <= an_in;
            an_q  <= an_m;
        end
    end

`ifdef SEG7_SCAN_ACTIVE_LOW_SEG_EN
    assign s_seg = ~seg_q;
`else
    assign s_seg = seg_q;
`endif
    assign s_an    = an_q;
    assign one_low = $onehot(~s_an);
    assign same    = (s_seg == ref_seg) && (s_an == ref_an);
    assign dec     = decode(ref_seg);

    // A changed sample is itself the first sample of the next dwell, so a
    // digit-to-digit transition costs no extra cycle through IDLE.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        inc     = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (one_low) begin
                    load    = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!same) begin
                    load    = one_low;
                    state_d = one_low ? COUNT : IDLE;
                end else if (cnt >= CW'(STABLE_CYCLES - 1)) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end else begin
                    inc = 1'b1;
                end
            end
            HOLD: begin
                if (!same) begin
                    load    = one_low;
                    state_d = one_low ? COUNT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_seg     <= '0;
            ref_an      <= '1;
            cnt         <= '0;
            shadow      <= '0;
            mask        <= '0;
            hex_out     <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (load) begin
                ref_seg <= s_seg;
                ref_an  <= s_an;
                cnt     <= CW'(1);
            end else if (inc) begin
                cnt <= cnt + CW'(1);
            end else if (state_d == IDLE) begin
                cnt <= '0;
            end

            err <= accept && !dec[4];

            if (&mask) begin
                hex_out     <= shadow;
                frame_valid <= 1'b1;
                mask        <= '0;
            end else begin
                frame_valid <= 1'b0;
                if (accept && dec[4]) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (!ref_an[i]) begin
                            shadow[4*i +: 4] <= dec[3:0];
                            mask[i]          <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
